// File: rtl/bytecode_fetch_seq_pkg.sv
// Shared constants for the bytecode fetch sequencer: operand-count width,
// the opcodes that need special handling, and the sequencer state encoding.
package bytecode_fetch_seq_pkg;

    localparam int PARAM_LEN  = 3;
    localparam int MAX_PARAMS = 4;

    localparam logic [7:0] OP_WIDE         = 8'hC4;
    localparam logic [7:0] OP_TABLESWITCH  = 8'hAA;
    localparam logic [7:0] OP_LOOKUPSWITCH = 8'hAB;

    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_FETCH = 3'd1,
        SEQ_CHECK = 3'd2,
        SEQ_PARAM = 3'd3,
        SEQ_EMIT  = 3'd4,
        SEQ_ERR   = 3'd5
    } seq_state_e;

    // Switch instructions carry alignment padding and a table, so their length
    // cannot come from a fixed count.
    function automatic logic is_variable_len(input logic [7:0] op);
        return (op == OP_TABLESWITCH) || (op == OP_LOOKUPSWITCH);
    endfunction

endpackage

// File: rtl/bytecode_fetch_seq_count_rom.sv
// Opcode to fixed operand-byte count for the JVM instruction set.
// Opcodes that take no operands (and unknown ones) map to zero.
module count_rom
    import bytecode_fetch_seq_pkg::*;
(
    input  logic [7:0]           opcode_i,
    output logic [PARAM_LEN-1:0] count_o
);

    always_comb begin
        count_o = '0;
        case (opcode_i) inside
            8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3A], 8'hA9, 8'hBC:
                count_o = PARAM_LEN'(1);
            8'h11, 8'h13, 8'h14, 8'h84, [8'h99:8'hA8], [8'hB2:8'hB8],
            8'hBB, 8'hBD, 8'hC0, 8'hC1, 8'hC6, 8'hC7:
                count_o = PARAM_LEN'(2);
            8'hC5:
                count_o = PARAM_LEN'(3);
            8'hB9, 8'hBA, 8'hC8, 8'hC9:
                count_o = PARAM_LEN'(4);
            default:
                count_o = '0;
        endcase
    end

endmodule

// File: rtl/bytecode_fetch_seq.sv
// Walks JVM bytecode in iram one instruction at a time, resolving the wide
// prefix and collecting operands, and hands decoded records downstream.
module bytecode_fetch_seq
    import bytecode_fetch_seq_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    start_pc,
    input  logic                 stop,
    input  logic                 redirect,
    input  logic [ADDR_W-1:0]    redirect_pc,
    output logic [ADDR_W-1:0]    iram_addr,
    input  logic [7:0]           iram_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_opcode,
    output logic                 out_wide,
    output logic [PARAM_LEN-1:0] out_count,
    output logic [31:0]          out_params,
    output logic [ADDR_W-1:0]    out_pc,
    output logic                 busy,
    output logic                 err
);

    seq_state_e           state_q;
    logic [ADDR_W-1:0]    pc_q;
    logic [ADDR_W-1:0]    op_pc_q;
    logic                 wide_q;
    logic                 stop_pend_q;
    logic                 err_q;
    logic                 out_valid_q;
    logic [7:0]           opcode_q;
    logic [PARAM_LEN-1:0] cnt_q;
    logic [PARAM_LEN-1:0] rem_q;
    logic [31:0]          params_q;

    logic [PARAM_LEN-1:0] rom_cnt;
    logic [PARAM_LEN:0]   eff_cnt_d;
    logic                 fault_d;
    logic                 active;
    logic                 accept;

    count_rom u_count_rom (
        .opcode_i (iram_data),
        .count_o  (rom_cnt)
    );

    assign active = (state_q != SEQ_IDLE) && (state_q != SEQ_ERR);
    assign accept = out_valid_q && out_ready;

    // One extra bit so a doubled count never aliases back into range.
    assign eff_cnt_d = wide_q ? {rom_cnt, 1'b0} : {1'b0, rom_cnt};

    always_comb begin
        fault_d = 1'b0;
        if (iram_data == OP_WIDE) begin
            fault_d = wide_q;
        end else if (is_variable_len(iram_data)) begin
            fault_d = 1'b1;
        end else if (wide_q && (rom_cnt == '0)) begin
            fault_d = 1'b1;
        end else if (eff_cnt_d > (PARAM_LEN + 1)'(MAX_PARAMS)) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= SEQ_IDLE;
            pc_q        <= '0;
            op_pc_q     <= '0;
            wide_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            opcode_q    <= '0;
            cnt_q       <= '0;
            rem_q       <= '0;
            params_q    <= '0;
        end else begin
            if (stop && active) begin
                stop_pend_q <= 1'b1;
            end

            if (redirect && active) begin
                pc_q        <= redirect_pc;
                op_pc_q     <= redirect_pc;
                wide_q      <= 1'b0;
                out_valid_q <= 1'b0;
                state_q     <= SEQ_FETCH;
            end else begin
                case (state_q)
                    SEQ_IDLE, SEQ_ERR: begin
                        if (start) begin
                            pc_q        <= start_pc;
                            op_pc_q     <= start_pc;
                            wide_q      <= 1'b0;
                            err_q       <= 1'b0;
                            stop_pend_q <= 1'b0;
                            state_q     <= SEQ_FETCH;
                        end
                    end
                    SEQ_FETCH: begin
                        pc_q    <= pc_q + ADDR_W'(1);
                        state_q <= SEQ_CHECK;
                    end
                    SEQ_CHECK: begin
                        if (fault_d) begin
                            err_q   <= 1'b1;
                            wide_q  <= 1'b0;
                            state_q <= SEQ_ERR;
                        end else if (iram_data == OP_WIDE) begin
                            // The next byte is already in flight, so stay here.
                            wide_q <= 1'b1;
                            pc_q   <= pc_q + ADDR_W'(1);
                        end else begin
                            opcode_q <= iram_data;
                            cnt_q    <= eff_cnt_d[PARAM_LEN-1:0];
                            params_q <= '0;
                            if (eff_cnt_d == '0) begin
                                out_valid_q <= 1'b1;
                                state_q     <= SEQ_EMIT;
                            end else begin
                                pc_q    <= pc_q + ADDR_W'(1);
                                rem_q   <= eff_cnt_d[PARAM_LEN-1:0];
                                state_q <= SEQ_PARAM;
                            end
                        end
                    end
                    SEQ_PARAM: begin
                        params_q <= {params_q[23:0], iram_data};
                        rem_q    <= rem_q - PARAM_LEN'(1);
                        // Skip the bump on the last byte so pc lands on the next opcode.
                        if (rem_q > PARAM_LEN'(1)) begin
                            pc_q <= pc_q + ADDR_W'(1);
                        end
                        if (rem_q == PARAM_LEN'(1)) begin
                            out_valid_q <= 1'b1;
                            state_q     <= SEQ_EMIT;
                        end
                    end
                    SEQ_EMIT: begin
                        if (accept) begin
                            out_valid_q <= 1'b0;
                            wide_q      <= 1'b0;
                            op_pc_q     <= pc_q;
                            if (stop_pend_q || stop) begin
                                stop_pend_q <= 1'b0;
                                state_q     <= SEQ_IDLE;
                            end else begin
                                state_q <= SEQ_FETCH;
                            end
                        end
                    end
                    default: begin
                        state_q <= SEQ_IDLE;
                    end
                endcase
            end
        end
    end

    assign iram_addr  = pc_q;
    assign out_valid  = out_valid_q;
    assign out_opcode = opcode_q;
    assign out_wide   = wide_q;
    assign out_count  = cnt_q;
    assign out_params = params_q;
    assign out_pc     = op_pc_q;
    assign busy       = (state_q != SEQ_IDLE);
    assign err        = err_q;

endmodule

// File: tb/tb_bytecode_fetch_seq.sv
// Directed bench for bytecode_fetch_seq: an instruction-level model of the
// bytecode stream predicts every record, checked on each valid cycle.
module tb_bytecode_fetch_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] start_pc;
    logic        stop;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic [11:0] iram_addr;
    logic [7:0]  iram_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_opcode;
    logic        out_wide;
    logic [2:0]  out_count;
    logic [31:0] out_params;
    logic [11:0] out_pc;
    logic        busy;
    logic        err;

    typedef struct {
        logic [7:0]  op;
        logic        wide;
        logic [2:0]  cnt;
        logic [31:0] params;
        logic [11:0] pc;
    } rec_t;

    logic [7:0] mem [0:4095];
    rec_t       exp_q[$];
    int         vectors;
    int         miscompares;
    int         valid_cycles;

    bytecode_fetch_seq #(.ADDR_W(12)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_pc    (start_pc),
        .stop        (stop),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .iram_addr   (iram_addr),
        .iram_data   (iram_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_wide    (out_wide),
        .out_count   (out_count),
        .out_params  (out_params),
        .out_pc      (out_pc),
        .busy        (busy),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // iram: byte of the address presented in the previous cycle
    always @(posedge clk) iram_data <= mem[iram_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // JVM fixed operand-byte counts
    function automatic int jvm_operands(input logic [7:0] op);
        if (op inside {8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3A], 8'hA9, 8'hBC}) return 1;
        if (op inside {8'h11, 8'h13, 8'h14, 8'h84, [8'h99:8'hA8], [8'hB2:8'hB8],
                       8'hBB, 8'hBD, 8'hC0, 8'hC1, 8'hC6, 8'hC7}) return 2;
        if (op == 8'hC5) return 3;
        if (op inside {8'hB9, 8'hBA, 8'hC8, 8'hC9}) return 4;
        return 0;
    endfunction

    // Decode nrec consecutive instructions from spc into expected records.
    task automatic model_walk(input int spc, input int nrec);
        int pc;
        pc = spc;
        for (int r = 0; r < nrec; r++) begin
            rec_t e;
            int   n;
            e.pc   = 12'(pc % 4096);
            e.wide = 1'b0;
            e.op   = mem[pc % 4096];
            if (e.op == 8'hC4) begin
                e.wide = 1'b1;
                pc     = pc + 1;
                e.op   = mem[pc % 4096];
            end
            n        = jvm_operands(e.op) * (e.wide ? 2 : 1);
            e.cnt    = 3'(n);
            e.params = 32'h0;
            for (int k = 0; k < n; k++)
                e.params = (e.params << 8) | 32'(mem[(pc + 1 + k) % 4096]);
            pc = pc + 1 + n;
            exp_q.push_back(e);
        end
    endtask

    // Compare process: every valid cycle is checked against the head record.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1) begin
            valid_cycles++;
            if (exp_q.size() == 0) begin
                chk("unexpected_record", 32'(out_valid), 32'h0);
            end else begin
                chk("rec_opcode", 32'(out_opcode), 32'(exp_q[0].op));
                chk("rec_wide",   32'(out_wide),   32'(exp_q[0].wide));
                chk("rec_count",  32'(out_count),  32'(exp_q[0].cnt));
                chk("rec_params", out_params,      exp_q[0].params);
                chk("rec_pc",     32'(out_pc),     32'(exp_q[0].pc));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_reached", 32'(busy), 32'h0);
    endtask

    task automatic wait_err(input int budget);
        int n;
        n = 0;
        while (!err && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("err_set", 32'(err), 32'h1);
    endtask

    // Run until the model queue holds one record, then stop after it.
    task automatic run_stream(input logic [11:0] spc);
        int n;
        @(posedge clk); #1 start = 1'b1; start_pc = spc;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (exp_q.size() > 1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        wait_idle(200);
        chk("records_left", 32'(exp_q.size()), 32'h0);
    endtask

    // Single instruction with FETCH-to-EMIT latency measured in cycles.
    task automatic run_one(input logic [11:0] spc, input int exp_lat, input bit glitch);
        int t;
        @(posedge clk); #1 start = 1'b1; start_pc = spc;
        @(posedge clk); #1 start = 1'b0; stop = 1'b1;
        if (glitch) begin
            #1 reset = 1'b0;
            #2 reset = 1'b1;
        end
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1;
            stop = 1'b0;
            t++;
        end
        stop = 1'b0;
        chk("emit_latency", 32'(t), 32'(exp_lat));
        wait_idle(100);
        chk("records_left", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        valid_cycles = 0;
        reset        = 1'b0;
        start        = 1'b0;
        start_pc     = '0;
        stop         = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = '0;
        out_ready    = 1'b1;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h010] = 8'h03; mem[12'h011] = 8'h10; mem[12'h012] = 8'h7F;
        mem[12'h020] = 8'hC4; mem[12'h021] = 8'h84; mem[12'h022] = 8'h01;
        mem[12'h023] = 8'h02; mem[12'h024] = 8'hFF; mem[12'h025] = 8'hFE;
        mem[12'h026] = 8'h03;
        mem[12'h030] = 8'h11; mem[12'h031] = 8'h11; mem[12'h032] = 8'h22;
        mem[12'h040] = 8'hA7; mem[12'h041] = 8'h00; mem[12'h042] = 8'h05;
        mem[12'h100] = 8'h03;
        mem[12'h050] = 8'hC4; mem[12'h051] = 8'hC4;
        mem[12'h060] = 8'hAA;
        mem[12'h000] = 8'h10; mem[12'h001] = 8'h55;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",      32'(busy),      32'h0);
        chk("reset_valid",     32'(out_valid), 32'h0);
        chk("reset_err",       32'(err),       32'h0);
        chk("reset_iram_addr", 32'(iram_addr), 32'h0);
        reset = 1'b1;

        // iconst_0 then bipush 0x7F
        model_walk(12'h010, 2);
        chk("model_iconst_cnt",    32'(exp_q[0].cnt), 32'h0);
        chk("model_bipush_params", exp_q[1].params,   32'h0000007F);
        run_stream(12'h010);
        model_walk(12'h011, 1);
        run_one(12'h011, 3, 1'b0);

        // wide iinc followed by iconst_0
        model_walk(12'h020, 2);
        chk("model_wide_params", exp_q[0].params,  32'h0102FFFE);
        chk("model_next_pc",     32'(exp_q[1].pc), 32'h026);
        run_stream(12'h020);
        model_walk(12'h020, 1);
        run_one(12'h020, 7, 1'b0);
        chk("pc_after_wide", 32'(iram_addr), 32'h026);

        // sipush held by a stalled translator
        model_walk(12'h030, 1);
        chk("model_sipush_params", exp_q[0].params, 32'h00001122);
        out_ready    = 1'b0;
        valid_cycles = 0;
        @(posedge clk); #1 start = 1'b1; start_pc = 12'h030;
        @(posedge clk); #1 start = 1'b0; stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        begin
            int n;
            n = 0;
            while (!out_valid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
        end
        repeat (5) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_valid_cycles", 32'(valid_cycles), 32'h6);
        chk("stall_valid_drop",   32'(out_valid),    32'h0);
        wait_idle(50);
        chk("records_left", 32'(exp_q.size()), 32'h0);

        // redirect during PARAM of goto
        model_walk(12'h100, 1);
        @(posedge clk); #1 start = 1'b1; start_pc = 12'h040;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 12'h100;
        @(posedge clk); #1 redirect = 1'b0; stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        begin
            int n;
            n = 0;
            while (!out_valid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk("redirect_rec_pc", 32'(out_pc), 32'h100);
        wait_idle(50);
        chk("records_left", 32'(exp_q.size()), 32'h0);

        // double wide prefix faults, start recovers
        @(posedge clk); #1 start = 1'b1; start_pc = 12'h050;
        @(posedge clk); #1 start = 1'b0;
        wait_err(20);
        chk("fault_busy",  32'(busy),      32'h1);
        chk("fault_valid", 32'(out_valid), 32'h0);
        model_walk(12'h000, 1);
        run_one(12'h000, 3, 1'b0);
        chk("err_cleared", 32'(err), 32'h0);

        // tableswitch faults
        @(posedge clk); #1 start = 1'b1; start_pc = 12'h060;
        @(posedge clk); #1 start = 1'b0;
        wait_err(20);
        chk("fault_valid", 32'(out_valid), 32'h0);
        model_walk(12'h000, 1);
        run_one(12'h000, 3, 1'b0);
        chk("err_cleared", 32'(err), 32'h0);

        // reset mid-PARAM
        @(posedge clk); #1 start = 1'b1; start_pc = 12'h040;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("midreset_busy",      32'(busy),       32'h0);
        chk("midreset_valid",     32'(out_valid),  32'h0);
        chk("midreset_iram_addr", 32'(iram_addr),  32'h0);
        chk("midreset_pc",        32'(out_pc),     32'h0);
        chk("midreset_params",    out_params,      32'h0);
        chk("midreset_opcode",    32'(out_opcode), 32'h0);
        reset = 1'b1;

        // reset glitch between edges is ignored
        model_walk(12'h011, 1);
        run_one(12'h011, 3, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
